// File: rtl/v_sync_if.sv
// Vertical timing stage bus: horizontal-stage inputs in, vertical timing out.
interface v_sync_if;
  logic       en;
  logic       hsync;
  logic       h_de;
  logic       vsync;
  logic       v_de;
  logic       de;
  logic [9:0] pixel_row;
  logic       frame_start;

  // Side that feeds horizontal timing and consumes vertical timing.
  modport master (
    output en,
    output hsync,
    output h_de,
    input  vsync,
    input  v_de,
    input  de,
    input  pixel_row,
    input  frame_start
  );

  // Vertical timing stage itself.
  modport slave (
    input  en,
    input  hsync,
    input  h_de,
    output vsync,
    output v_de,
    output de,
    output pixel_row,
    output frame_start
  );
endinterface

// File: rtl/v_sync.sv
// Vertical timing stage: counts lines on hsync falling edges and produces
// vsync, vertical data-enable, active row index and a frame-start strobe.
module v_sync #(
  parameter int unsigned PULSE_LINES  = 2,
  parameter int unsigned BACK_PORCH   = 33,
  parameter int unsigned ACTIVE_LINES = 480,
  parameter int unsigned FRONT_PORCH  = 10
) (
  input logic   clk,
  input logic   rst_n,
  v_sync_if.slave bus
);

  localparam int unsigned TOTAL   = PULSE_LINES + BACK_PORCH + ACTIVE_LINES + FRONT_PORCH;
  localparam int unsigned ACT_MIN = PULSE_LINES + BACK_PORCH;
  localparam int unsigned ACT_MAX = ACT_MIN + ACTIVE_LINES;

  // Region bounds are compared at 11 bits so ACT_MAX == 1024 stays representable.
  localparam logic [10:0] PULSE_END = 11'(PULSE_LINES);
  localparam logic [10:0] ACT_LO    = 11'(ACT_MIN);
  localparam logic [10:0] ACT_HI    = 11'(ACT_MAX);
  localparam logic [9:0]  LAST_LINE = 10'(TOTAL - 1);
  localparam logic [9:0]  ROW_BASE  = 10'(ACT_MIN);

  if (TOTAL == 0 || TOTAL > 1024) begin : g_bad_total
    $error("v_sync: frame length must be between 1 and 1024 lines");
  end

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    SP   = 5'b00010,
    BP   = 5'b00100,
    AP   = 5'b01000,
    FP   = 5'b10000
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       hsync_d;
  logic       tick;
  logic [9:0] line_idx;
  logic [9:0] line_next;
  logic       started;
  logic       started_next;
  logic       vsync_q;
  logic       vsync_next;
  logic       v_de_q;
  logic       v_de_next;
  logic [9:0] row_q;
  logic [9:0] row_next;
  logic       fs_q;
  logic       fs_next;

  // Region of the frame a given line number falls in.
  function automatic state_t decode(input logic [9:0] line);
    logic [10:0] l;
    l = {1'b0, line};
    if (l < PULSE_END) begin
      return SP;
    end else if (l < ACT_LO) begin
      return BP;
    end else if (l < ACT_HI) begin
      return AP;
    end else begin
      return FP;
    end
  endfunction

  // A line starts on the falling edge of hsync while the stage is enabled.
  assign tick = bus.en & hsync_d & ~bus.hsync;

  // hsync history for edge detection; parked high while idle so that an
  // hsync already low when en rises still counts as the first edge.
  always_ff @(posedge clk) begin
    if (!rst_n || !bus.en) begin
      hsync_d <= 1'b1;
    end else begin
      hsync_d <= bus.hsync;
    end
  end

  // Next line number, region and registered outputs, all decoded from the
  // line value being loaded so that outputs carry no latency beyond the tick.
  always_comb begin
    line_next    = line_idx;
    started_next = started;
    state_next   = state;
    vsync_next   = vsync_q;
    v_de_next    = v_de_q;
    row_next     = row_q;
    fs_next      = 1'b0;
    if (!bus.en) begin
      line_next    = '0;
      started_next = 1'b0;
      state_next   = IDLE;
      vsync_next   = 1'b1;
      v_de_next    = 1'b0;
      row_next     = '0;
    end else if (tick) begin
      if (!started) begin
        started_next = 1'b1;
        line_next    = '0;
      end else if (line_idx == LAST_LINE) begin
        line_next = '0;
      end else begin
        line_next = line_idx + 10'd1;
      end
      state_next = decode(line_next);
      vsync_next = (state_next != SP);
      v_de_next  = (state_next == AP);
      row_next   = (state_next == AP) ? (line_next - ROW_BASE) : '0;
      fs_next    = (line_next == '0);
    end
  end

  // Frame region register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Line counter and registered timing outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_idx <= '0;
      started  <= 1'b0;
      vsync_q  <= 1'b1;
      v_de_q   <= 1'b0;
      row_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      line_idx <= line_next;
      started  <= started_next;
      vsync_q  <= vsync_next;
      v_de_q   <= v_de_next;
      row_q    <= row_next;
      fs_q     <= fs_next;
    end
  end

  assign bus.vsync       = vsync_q;
  assign bus.v_de        = v_de_q;
  assign bus.pixel_row   = row_q;
  assign bus.frame_start = fs_q;
  assign bus.de          = bus.h_de & v_de_q;

endmodule

// File: tb/tb_v_sync.sv
// Self-checking bench for v_sync with a line-number reference model.
module tb_v_sync;
  localparam int PL   = 2;
  localparam int BPL  = 3;
  localparam int AL   = 4;
  localparam int FPL  = 1;
  localparam int TOT  = PL + BPL + AL + FPL;
  localparam int AMIN = PL + BPL;
  localparam int AMAX = AMIN + AL;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  v_sync_if bus ();

  v_sync #(
    .PULSE_LINES (PL),
    .BACK_PORCH  (BPL),
    .ACTIVE_LINES(AL),
    .FRONT_PORCH (FPL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: current line number of the frame (-1 = not running),
  // last seen hsync level, and whether this cycle follows a line-0 load.
  int m_line = -1;
  bit m_hsd  = 1'b1;
  bit m_fs   = 1'b0;

  function automatic logic [13:0] expected();
    logic       vs;
    logic       vde;
    logic [9:0] row;
    vs  = !(m_line >= 0 && m_line < PL);
    vde = (m_line >= AMIN && m_line < AMAX);
    row = vde ? 10'(m_line - AMIN) : 10'd0;
    return {vs, vde, m_fs, bus.h_de & vde, row};
  endfunction

  function automatic logic [13:0] observed();
    return {bus.vsync, bus.v_de, bus.frame_start, bus.de, bus.pixel_row};
  endfunction

  // Clock edge: advance the model with the inputs seen at the edge, then
  // compare all outputs against it just after the edge.
  task automatic step();
    bit tk;
    @(posedge clk);
    if (!rst_n || !bus.en) begin
      m_hsd  = 1'b1;
      m_line = -1;
      m_fs   = 1'b0;
    end else begin
      tk    = m_hsd && !bus.hsync;
      m_hsd = bus.hsync;
      m_fs  = 1'b0;
      if (tk) begin
        m_line = (m_line < 0) ? 0 : (m_line + 1) % TOT;
        m_fs   = (m_line == 0);
      end
    end
    #1;
    vectors++;
    if (observed() !== expected()) begin
      miscompares++;
      $display("FAIL model t=%0t {vsync,v_de,fs,de,row} got %b want %b",
               $time, observed(), expected());
    end
  endtask

  // One cycle of an 8-cycle line at position c with hsync low for low_len cycles.
  task automatic drive_h(input int c, input int low_len);
    bus.hsync = (c < low_len) ? 1'b0 : 1'b1;
    bus.h_de  = (c >= 4 && c <= 6) ? 1'b1 : 1'b0;
    step();
  endtask

  task automatic run_lines(input int n);
    for (int l = 0; l < n; l++) begin
      for (int c = 0; c < 8; c++) drive_h(c, 2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.hsync = 1'b1;
    bus.h_de = 1'b0;
    for (int i = 0; i < 3; i++) step();
    vectors++;
    if ({bus.vsync, bus.v_de, bus.frame_start, bus.pixel_row} !== {1'b1, 1'b0, 1'b0, 10'd0}) begin
      miscompares++;
      $display("FAIL reset_values got vs=%b vde=%b fs=%b row=%0d want 1 0 0 0",
               bus.vsync, bus.v_de, bus.frame_start, bus.pixel_row);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_frames();
    int fs_at[$];
    int de_cnt[25];
    int vs_low;
    int want;
    vs_low = 0;
    foreach (de_cnt[i]) de_cnt[i] = 0;
    bus.en = 1'b1;
    for (int l = 0; l < 25; l++) begin
      for (int c = 0; c < 8; c++) begin
        drive_h(c, 2);
        if (bus.frame_start) fs_at.push_back(l);
        if (bus.de) de_cnt[l]++;
        if (!bus.vsync) vs_low++;
      end
      if ((l % 10) >= 5 && (l % 10) <= 8) begin
        vectors++;
        if (bus.pixel_row !== 10'((l % 10) - 5)) begin
          miscompares++;
          $display("FAIL frame_row line %0d got %0d want %0d", l, bus.pixel_row, (l % 10) - 5);
        end
      end
    end
    vectors++;
    if (fs_at.size() != 3) begin
      miscompares++;
      $display("FAIL frame_start_count got %0d want 3", fs_at.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (fs_at[i] != i * 10) begin
          miscompares++;
          $display("FAIL frame_start_line #%0d got %0d want %0d", i, fs_at[i], i * 10);
        end
      end
    end
    vectors++;
    if (vs_low != 48) begin
      miscompares++;
      $display("FAIL vsync_low_cycles got %0d want 48", vs_low);
    end
    for (int l = 0; l < 25; l++) begin
      want = ((l % 10) >= 5 && (l % 10) <= 8) ? 3 : 0;
      vectors++;
      if (de_cnt[l] != want) begin
        miscompares++;
        $display("FAIL de_cycles line %0d got %0d want %0d", l, de_cnt[l], want);
      end
    end
  endtask

  task automatic test_en_drop();
    int k;
    int idle_n;
    run_lines(1);
    k = $urandom_range(3, 7);
    for (int c = 0; c < k; c++) drive_h(c, 2);
    vectors++;
    if ({bus.v_de, bus.pixel_row} !== {1'b1, 10'd1}) begin
      miscompares++;
      $display("FAIL en_drop_pre got vde=%b row=%0d want 1 1", bus.v_de, bus.pixel_row);
    end
    bus.en = 1'b0;
    drive_h(k, 2);
    vectors++;
    if ({bus.vsync, bus.v_de, bus.frame_start, bus.pixel_row} !== {1'b1, 1'b0, 1'b0, 10'd0}) begin
      miscompares++;
      $display("FAIL en_drop_idle got vs=%b vde=%b fs=%b row=%0d want 1 0 0 0",
               bus.vsync, bus.v_de, bus.frame_start, bus.pixel_row);
    end
    idle_n = $urandom_range(3, 12);
    for (int i = 0; i < idle_n; i++) begin
      bus.hsync = 1'($urandom_range(0, 1));
      bus.h_de  = 1'($urandom_range(0, 1));
      step();
    end
    bus.en = 1'b1;
    drive_h(0, 2);
    vectors++;
    if ({bus.frame_start, bus.vsync, bus.pixel_row} !== {1'b1, 1'b0, 10'd0}) begin
      miscompares++;
      $display("FAIL en_restart got fs=%b vs=%b row=%0d want 1 0 0",
               bus.frame_start, bus.vsync, bus.pixel_row);
    end
    for (int c = 1; c < 8; c++) drive_h(c, 2);
  endtask

  task automatic test_rst_mid_ap();
    run_lines(5);
    for (int c = 0; c < 4; c++) drive_h(c, 2);
    vectors++;
    if (bus.v_de !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre_ap got vde=%b want 1", bus.v_de);
    end
    rst_n = 1'b0;
    drive_h(4, 2);
    vectors++;
    if ({bus.vsync, bus.v_de, bus.frame_start, bus.pixel_row} !== {1'b1, 1'b0, 1'b0, 10'd0}) begin
      miscompares++;
      $display("FAIL rst_mid_ap got vs=%b vde=%b fs=%b row=%0d want 1 0 0 0",
               bus.vsync, bus.v_de, bus.frame_start, bus.pixel_row);
    end
    rst_n = 1'b1;
    for (int c = 5; c < 8; c++) begin
      drive_h(c, 2);
      vectors++;
      if ({bus.frame_start, bus.vsync, bus.v_de} !== {1'b0, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL rst_no_tick got fs=%b vs=%b vde=%b want 0 1 0",
                 bus.frame_start, bus.vsync, bus.v_de);
      end
    end
    drive_h(0, 2);
    vectors++;
    if ({bus.frame_start, bus.vsync} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_restart got fs=%b vs=%b want 1 0", bus.frame_start, bus.vsync);
    end
    for (int c = 1; c < 8; c++) drive_h(c, 2);
  endtask

  task automatic test_hsync_hold();
    run_lines(5);
    for (int c = 0; c < 8; c++) begin
      drive_h(c, 5);
      vectors++;
      if (bus.pixel_row !== 10'd1) begin
        miscompares++;
        $display("FAIL hold_single_tick cycle %0d got row=%0d want 1", c, bus.pixel_row);
      end
    end
    run_lines(3);
    vectors++;
    if ({bus.vsync, bus.v_de} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL last_line got vs=%b vde=%b want 1 0", bus.vsync, bus.v_de);
    end
    drive_h(0, 2);
    vectors++;
    if ({bus.frame_start, bus.vsync} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL wrap got fs=%b vs=%b want 1 0", bus.frame_start, bus.vsync);
    end
    for (int c = 1; c < 8; c++) drive_h(c, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      bus.en    = ($urandom_range(0, 99) != 0);
      bus.hsync = ($urandom_range(0, 2) != 0);
      bus.h_de  = 1'($urandom_range(0, 1));
      step();
    end
    rst_n  = 1'b1;
    bus.en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_en_drop();
    test_rst_mid_ap();
    test_hsync_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
